button_debouncer: RTL

//  Input-side conditioning for the board push-buttons (north/east/south/west).

---
 rtl/button_debouncer_pkg.sv | 32 +++
 rtl/debounce_chan.sv | 153 +++++++++++++++
 rtl/button_debouncer.sv | 62 ++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
//  Shared definitions for the push-button conditioning block:
//   - default timing parameters for a 50 MHz system clock
//   - board button index constants (north/east/south/west)
//   - repeat-phase state type used when BTN_REPEAT_EN is defined
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

  // Defaults at 50 MHz: 10 ms debounce, 500 ms first repeat, 100 ms repeat.
  localparam int unsigned DEF_NUM_BTN         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned DEF_CNT_W           = 19;
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;
  localparam int unsigned DEF_RPT_W           = 25;

  // Board button indices into btn_in / btn_level / btn_press / btn_release.
  localparam int unsigned BTN_NORTH = 0;
  localparam int unsigned BTN_EAST  = 1;
  localparam int unsigned BTN_SOUTH = 2;
  localparam int unsigned BTN_WEST  = 3;

  // Auto-repeat phase of one channel: idle while released, waiting out the
  // initial delay, then strobing on the shorter period.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
//  One push-button channel: two-flop synchroniser, debounce counter,
//  debounced level and registered one-cycle press/release strobes.
//  Optional auto-repeat of the press strobe when BTN_REPEAT_EN is defined.
//
//  Ports
//   i_clk      in   system clock
//   i_rst      in   synchronous active-high reset
//   i_btn      in   raw asynchronous button pin, active-high
//   o_level    out  debounced button state
//   o_press    out  one-cycle strobe on accepted 0->1 (and on repeats)
//   o_release  out  one-cycle strobe on accepted 1->0
//
//  Configuration macro: BTN_REPEAT_EN
// -----------------------------------------------------------------------------
module debounce_chan
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
`ifdef BTN_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned RPT_W           = DEF_RPT_W
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_accept;
  logic w_rpt_fire;

  // Synchronised input disagrees with the debounced level; once it has done
  // so for DEBOUNCE_CYCLES consecutive samples the new value is accepted.
  assign w_diff   = r_sync2 ^ r_level;
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;

      // Any agreement restarts the count, so short glitches never complete it.
      if (!w_diff || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_accept) begin
        r_level <= r_sync2;
      end

      // Strobes rise together with the level change they announce.
      r_press   <= (w_accept && r_sync2) || w_rpt_fire;
      r_release <= w_accept && !r_sync2;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  rpt_state_e       r_rpt_state;
  rpt_state_e       w_rpt_state_nxt;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic [RPT_W-1:0] w_rpt_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rpt_state <= RPT_IDLE;
      r_rpt_cnt   <= '0;
    end else begin
      r_rpt_state <= w_rpt_state_nxt;
      r_rpt_cnt   <= w_rpt_cnt_nxt;
    end
  end

  // In the DELAY/PERIOD phases the level is 1, so any acceptance there is a
  // release and takes priority over a repeat landing on the same edge.
  always_comb begin
    w_rpt_state_nxt = r_rpt_state;
    w_rpt_cnt_nxt   = r_rpt_cnt;
    w_rpt_fire      = 1'b0;
    case (r_rpt_state)
      RPT_IDLE: begin
        if (w_accept && r_sync2) begin
          w_rpt_state_nxt = RPT_DELAY;
          w_rpt_cnt_nxt   = '0;
        end
      end
      RPT_DELAY: begin
        if (w_accept) begin
          w_rpt_state_nxt = RPT_IDLE;
          w_rpt_cnt_nxt   = '0;
        end else if (r_rpt_cnt == RPT_DELAY_LAST) begin
          w_rpt_fire      = 1'b1;
          w_rpt_state_nxt = RPT_PERIOD;
          w_rpt_cnt_nxt   = '0;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
        end
      end
      RPT_PERIOD: begin
        if (w_accept) begin
          w_rpt_state_nxt = RPT_IDLE;
          w_rpt_cnt_nxt   = '0;
        end else if (r_rpt_cnt == RPT_PERIOD_LAST) begin
          w_rpt_fire    = 1'b1;
          w_rpt_cnt_nxt = '0;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
        end
      end
      default: begin
        w_rpt_state_nxt = RPT_IDLE;
        w_rpt_cnt_nxt   = '0;
      end
    endcase
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//  Input-side conditioning for the board push-buttons. Each of NUM_BTN raw
//  pins is synchronised, debounced independently and turned into a clean
//  level plus one-cycle press/release strobes.
//
//  Ports
//   clk          in   system clock (50 MHz)
//   rst          in   synchronous active-high reset
//   btn_in       in   [NUM_BTN] raw asynchronous button pins, active-high
//   btn_level    out  [NUM_BTN] debounced button state
//   btn_press    out  [NUM_BTN] one-cycle strobe on accepted press / repeat
//   btn_release  out  [NUM_BTN] one-cycle strobe on accepted release
//
//  Configuration macro: BTN_REPEAT_EN (auto-repeat of btn_press while held)
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned RPT_W           = DEF_RPT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .RPT_W           (RPT_W)
`endif
    ) u_chan (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_btn     (btn_in[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g])
    );
  end

`ifndef BTN_REPEAT_EN
  // Repeat parameters stay on the interface so both builds accept the same
  // override list; without the repeat feature they drive nothing.
  if ((RPT_W == 0) && (REPEAT_DELAY == 0) && (REPEAT_PERIOD == 0)) begin : g_rpt_ignored
  end
`endif

endmodule
